// File: rtl/key_pkg.sv
// Shared definitions for the key-driven BCD parameter editor: key bit positions,
// editor state encoding and per-digit BCD step helpers.
`timescale 1ns/1ps
`default_nettype none

package key_pkg;

  localparam int K_MODE  = 0;
  localparam int K_SHIFT = 1;
  localparam int K_UP    = 2;
  localparam int K_DOWN  = 3;

  typedef enum logic [1:0] {
    VIEW   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic key_onehot(input logic [3:0] k);
    return $onehot(k);
  endfunction

  // Digits outside 0..9 are forced back to 0 by either direction.
  function automatic logic [3:0] bcd_up(input logic [3:0] d);
    if (d >= BCD_MAX) return 4'd0;
    return d + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_down(input logic [3:0] d);
    if (d > BCD_MAX) return 4'd0;
    if (d == 4'd0)   return BCD_MAX;
    return d - 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_param_editor_if.sv
// Key-pulse input and committed-value / display outputs of the parameter editor.
`timescale 1ns/1ps
`default_nettype none

interface key_param_editor_if #(
  parameter int N_DIGITS = 4
);
  logic [3:0]            key_pos;
  logic [4*N_DIGITS-1:0] value_bcd;
  logic                  value_upd;
  logic [4*N_DIGITS-1:0] disp_bcd;
  logic [N_DIGITS-1:0]   disp_blank;
  logic                  edit_mode;
  logic [2:0]            cursor;

  modport master (
    output key_pos,
    input  value_bcd, value_upd, disp_bcd, disp_blank, edit_mode, cursor
  );

  modport slave (
    input  key_pos,
    output value_bcd, value_upd, disp_bcd, disp_blank, edit_mode, cursor
  );
endinterface

`default_nettype wire

// File: rtl/ms_tick.sv
// Free-running one-cycle pulse every CLK_FREQ/1000 clocks (1 ms time base).
`timescale 1ns/1ps
`default_nettype none

module ms_tick #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int DIV = (CLK_FREQ / 1000 < 1) ? 1 : CLK_FREQ / 1000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          tick_q;
  logic          wrap;

  assign wrap = (cnt_q == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= wrap;
      cnt_q  <= wrap ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick_o = tick_q;

endmodule

`default_nettype wire

// File: rtl/key_param_editor.sv
// BCD parameter editor driven by debounced key pulses: edits a working copy digit by
// digit, commits it on MODE, and feeds a blinking-cursor display.
`timescale 1ns/1ps
`default_nettype none

module key_param_editor
  import key_pkg::*;
#(
  parameter int                    CLK_FREQ   = 50_000_000,
  parameter int                    N_DIGITS   = 4,
  parameter logic [4*N_DIGITS-1:0] INIT_VAL   = 16'h1000,
  parameter int                    TIMEOUT_MS = 5000,
  parameter int                    BLINK_MS   = 250
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  key_param_editor_if.slave  bus
);

  localparam int VW   = 4 * N_DIGITS;
  localparam int TO_W = $clog2(TIMEOUT_MS + 1);
  localparam int BL_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_MS - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_MS - 1);
  localparam logic [2:0]      CUR_MAX = 3'(N_DIGITS - 1);

  state_t          state_q, state_d;
  logic [VW-1:0]   value_q, value_d;
  logic [VW-1:0]   work_q,  work_d;
  logic [VW-1:0]   disp_q,  disp_d;
  logic [2:0]      cursor_q, cursor_d;
  logic            upd_q,   upd_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [BL_W-1:0] bl_cnt_q, bl_cnt_d;
  logic            blink_q, blink_d;

  logic            tick;
  logic            key_ok;
  logic [3:0]      key;

  ms_tick #(
    .CLK_FREQ (CLK_FREQ)
  ) u_tick (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .tick_o (tick)
  );

  assign key    = bus.key_pos;
  assign key_ok = key_onehot(key);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= VIEW;
      value_q  <= INIT_VAL;
      work_q   <= INIT_VAL;
      disp_q   <= INIT_VAL;
      cursor_q <= 3'd0;
      upd_q    <= 1'b0;
      to_cnt_q <= '0;
      bl_cnt_q <= '0;
      blink_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      work_q   <= work_d;
      disp_q   <= disp_d;
      cursor_q <= cursor_d;
      upd_q    <= upd_d;
      to_cnt_q <= to_cnt_d;
      bl_cnt_q <= bl_cnt_d;
      blink_q  <= blink_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    work_d   = work_q;
    cursor_d = cursor_q;
    upd_d    = 1'b0;
    to_cnt_d = to_cnt_q;
    bl_cnt_d = bl_cnt_q;
    blink_d  = blink_q;

    unique case (state_q)
      VIEW: begin
        bl_cnt_d = '0;
        blink_d  = 1'b0;
        to_cnt_d = '0;
        if (key_ok && key[K_MODE]) begin
          state_d  = EDIT;
          work_d   = value_q;
          cursor_d = 3'd0;
        end
      end

      EDIT: begin
        if (key_ok) begin
          // An accepted key outranks both the tick increment and a pending expiry.
          to_cnt_d = '0;
          bl_cnt_d = '0;
          blink_d  = 1'b0;
          if (key[K_MODE]) begin
            state_d = COMMIT;
          end else if (key[K_SHIFT]) begin
            cursor_d = (cursor_q == CUR_MAX) ? 3'd0 : cursor_q + 3'd1;
          end else begin
            for (int i = 0; i < N_DIGITS; i++) begin
              if (cursor_q == 3'(i)) begin
                work_d[4*i +: 4] = key[K_UP] ? bcd_up(work_q[4*i +: 4])
                                             : bcd_down(work_q[4*i +: 4]);
              end
            end
          end
        end else if (tick) begin
          if (to_cnt_q >= TO_LAST) begin
            state_d  = VIEW;
            work_d   = value_q;
            to_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
          if (bl_cnt_q == BL_LAST) begin
            bl_cnt_d = '0;
            blink_d  = ~blink_q;
          end else begin
            bl_cnt_d = bl_cnt_q + BL_W'(1);
          end
        end
      end

      COMMIT: begin
        value_d = work_q;
        upd_d   = 1'b1;
        state_d = VIEW;
      end

      default: begin
        state_d = VIEW;
      end
    endcase
  end

  // Built from next-state values so the display tracks edits with the same one-cycle latency.
  always_comb begin
    disp_d = (state_d == VIEW) ? value_d : work_d;
  end

  always_comb begin
    bus.disp_blank = '0;
    if (state_q == EDIT) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (cursor_q == 3'(i)) bus.disp_blank[i] = blink_q;
      end
    end
  end

  assign bus.value_bcd = value_q;
  assign bus.value_upd = upd_q;
  assign bus.disp_bcd  = disp_q;
  assign bus.edit_mode = (state_q == EDIT);
  assign bus.cursor    = cursor_q;

endmodule

`default_nettype wire

// File: tb/tb_key_param_editor.sv
// Scoreboard bench for key_param_editor: commits are predicted into a queue and checked on value_upd.
`timescale 1ns/1ps
`default_nettype none

module tb_key_param_editor;

  localparam logic [3:0] KM = 4'b0001;
  localparam logic [3:0] KS = 4'b0010;
  localparam logic [3:0] KU = 4'b0100;
  localparam logic [3:0] KD = 4'b1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_param_editor_if #(.N_DIGITS(4)) bus ();
  key_param_editor_if #(.N_DIGITS(4)) bus2 ();

  key_param_editor #(
    .CLK_FREQ(10_000), .N_DIGITS(4), .INIT_VAL(16'h1000), .TIMEOUT_MS(3), .BLINK_MS(2)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus.slave)
  );

  key_param_editor #(
    .CLK_FREQ(10_000), .N_DIGITS(4), .INIT_VAL(16'h00FA), .TIMEOUT_MS(50), .BLINK_MS(2)
  ) dut2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus2.slave)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] sb_exp;

  // Every value_upd must retire exactly one predicted commit.
  always @(negedge clk) begin
    if (rst_n && bus.value_upd) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL upd_unexpected: value_upd=1 value_bcd=%h with no commit pending", bus.value_bcd);
      end else begin
        sb_exp = exp_q.pop_front();
        if (bus.value_bcd !== sb_exp) begin
          n_err++;
          $display("FAIL commit_value: got %h expected %h", bus.value_bcd, sb_exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic press(input logic [3:0] k);
    @(negedge clk); bus.key_pos = k;
    @(negedge clk); bus.key_pos = 4'b0000;
  endtask

  task automatic press2(input logic [3:0] k);
    @(negedge clk); bus2.key_pos = k;
    @(negedge clk); bus2.key_pos = 4'b0000;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.value_bcd !== 16'h1000) begin n_err++; $display("FAIL rst_value: got %h expected 1000", bus.value_bcd); end
    n_cmp++; if (bus.disp_bcd !== 16'h1000) begin n_err++; $display("FAIL rst_disp: got %h expected 1000", bus.disp_bcd); end
    n_cmp++; if (bus.edit_mode !== 1'b0 || bus.value_upd !== 1'b0) begin n_err++; $display("FAIL rst_flags: got edit=%b upd=%b expected 0 0", bus.edit_mode, bus.value_upd); end
    n_cmp++; if (bus.disp_blank !== 4'b0 || bus.cursor !== 3'd0) begin n_err++; $display("FAIL rst_blank_cursor: got %b/%0d expected 0000/0", bus.disp_blank, bus.cursor); end
    n_cmp++; if (bus2.value_bcd !== 16'h00FA) begin n_err++; $display("FAIL rst_value2: got %h expected 00fa", bus2.value_bcd); end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if (bus.value_bcd !== 16'h1000 || bus.disp_bcd !== 16'h1000) begin n_err++; $display("FAIL idle_value: got %h/%h expected 1000/1000", bus.value_bcd, bus.disp_bcd); end
    n_cmp++; if (bus.edit_mode !== 1'b0) begin n_err++; $display("FAIL idle_edit: got %b expected 0", bus.edit_mode); end
  endtask

  task automatic test_commit();
    press(KM);
    n_cmp++; if (bus.edit_mode !== 1'b1 || bus.cursor !== 3'd0) begin n_err++; $display("FAIL enter_edit: got edit=%b cur=%0d expected 1 0", bus.edit_mode, bus.cursor); end
    n_cmp++; if (bus.disp_bcd !== 16'h1000) begin n_err++; $display("FAIL enter_disp: got %h expected 1000", bus.disp_bcd); end
    press(KU);
    n_cmp++; if (bus.disp_bcd !== 16'h1001) begin n_err++; $display("FAIL up1: got %h expected 1001", bus.disp_bcd); end
    press(KU);
    n_cmp++; if (bus.disp_bcd !== 16'h1002 || bus.value_bcd !== 16'h1000) begin n_err++; $display("FAIL up2: got disp %h value %h expected 1002 1000", bus.disp_bcd, bus.value_bcd); end
    exp_q.push_back(16'h1002);
    press(KM);
    n_cmp++; if (bus.edit_mode !== 1'b0 || bus.value_upd !== 1'b0) begin n_err++; $display("FAIL commit_t1: got edit=%b upd=%b expected 0 0", bus.edit_mode, bus.value_upd); end
    @(negedge clk);
    n_cmp++; if (bus.value_upd !== 1'b1 || bus.value_bcd !== 16'h1002) begin n_err++; $display("FAIL commit_t2: got upd=%b value %h expected 1 1002", bus.value_upd, bus.value_bcd); end
    @(negedge clk);
    n_cmp++; if (bus.value_upd !== 1'b0 || bus.disp_bcd !== 16'h1002) begin n_err++; $display("FAIL commit_t3: got upd=%b disp %h expected 0 1002", bus.value_upd, bus.disp_bcd); end
  endtask

  task automatic test_shift_wrap();
    do_reset();
    press(KM);
    for (int i = 1; i <= 4; i++) begin
      press(KS);
      n_cmp++; if (bus.cursor !== 3'(i % 4)) begin n_err++; $display("FAIL shift_%0d: got cursor %0d expected %0d", i, bus.cursor, i % 4); end
    end
    press(KD);
    n_cmp++; if (bus.disp_bcd !== 16'h1009) begin n_err++; $display("FAIL down_wrap: got %h expected 1009", bus.disp_bcd); end
    exp_q.push_back(16'h1009);
    press(KM);
    repeat (2) @(negedge clk);
    press(KM);
    press(KU);
    n_cmp++; if (bus.disp_bcd !== 16'h1000) begin n_err++; $display("FAIL up_wrap_nocarry: got %h expected 1000", bus.disp_bcd); end
    exp_q.push_back(16'h1000);
    press(KM);
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.value_bcd !== 16'h1000) begin n_err++; $display("FAIL wrap_commit: got %h expected 1000", bus.value_bcd); end
  endtask

  task automatic test_timeout();
    int k;
    bit saw, bad;
    k = 0; saw = 0; bad = 0;
    press(KM);
    press(KU);
    n_cmp++; if (bus.disp_bcd !== 16'h1001 || bus.disp_blank !== 4'b0) begin n_err++; $display("FAIL to_up: got %h/%b expected 1001/0000", bus.disp_bcd, bus.disp_blank); end
    while (bus.edit_mode === 1'b1 && k < 100) begin
      @(negedge clk); k++;
      if (bus.edit_mode === 1'b1 && bus.disp_blank[0] === 1'b1) saw = 1;
      if ((bus.disp_blank & 4'b1110) !== 4'b0) bad = 1;
    end
    n_cmp++; if (bus.edit_mode !== 1'b0 || k < 20 || k > 32) begin n_err++; $display("FAIL timeout_time: got edit=%b after %0d cycles expected 0 within 20..32", bus.edit_mode, k); end
    n_cmp++; if (bus.value_bcd !== 16'h1000 || bus.disp_bcd !== 16'h1000) begin n_err++; $display("FAIL timeout_discard: got %h/%h expected 1000/1000", bus.value_bcd, bus.disp_bcd); end
    n_cmp++; if (saw !== 1'b1 || bad !== 1'b0 || bus.disp_blank !== 4'b0) begin n_err++; $display("FAIL blink: got saw=%b bad=%b blank=%b expected 1 0 0000", saw, bad, bus.disp_blank); end
  endtask

  task automatic test_ignore();
    int k, n, g;
    press(KM);
    press(KS);
    press(4'b0110);
    n_cmp++; if (bus.cursor !== 3'd1 || bus.disp_bcd !== 16'h1000) begin n_err++; $display("FAIL multihot_0110: got cur=%0d disp %h expected 1 1000", bus.cursor, bus.disp_bcd); end
    press(4'b1100);
    press(4'b0000);
    n_cmp++; if (bus.cursor !== 3'd1 || bus.disp_bcd !== 16'h1000 || bus.edit_mode !== 1'b1) begin n_err++; $display("FAIL multihot_1100: got cur=%0d disp %h edit=%b expected 1 1000 1", bus.cursor, bus.disp_bcd, bus.edit_mode); end
    k = 0;
    while (bus.edit_mode === 1'b1 && k < 60) begin
      @(negedge clk); bus.key_pos = 4'b0110; k++;
    end
    bus.key_pos = 4'b0000;
    n_cmp++; if (bus.edit_mode !== 1'b0 || k > 30) begin n_err++; $display("FAIL multihot_no_rearm: got edit=%b after %0d cycles expected 0 within 30", bus.edit_mode, k); end
    // Align a key with the tick that would expire the edit.
    press(KM);
    n = 0; g = 0;
    while (n < 3 && g < 100) begin
      if (dut.u_tick.tick_o === 1'b1) n++;
      if (n < 3) begin @(negedge clk); g++; end
    end
    bus.key_pos = KU;
    @(negedge clk); bus.key_pos = 4'b0000;
    n_cmp++; if (g >= 100 || bus.edit_mode !== 1'b1 || bus.disp_bcd !== 16'h1001) begin n_err++; $display("FAIL key_on_expiry: got edit=%b disp %h wait=%0d expected 1 1001", bus.edit_mode, bus.disp_bcd, g); end
    repeat (15) @(negedge clk);
    n_cmp++; if (bus.edit_mode !== 1'b1) begin n_err++; $display("FAIL expiry_rearm: got edit=%b expected 1", bus.edit_mode); end
    exp_q.push_back(16'h1001);
    press(KM);
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.value_bcd !== 16'h1001) begin n_err++; $display("FAIL expiry_commit: got %h expected 1001", bus.value_bcd); end
  endtask

  task automatic test_illegal_digit();
    press2(KM);
    press2(KU);
    n_cmp++; if (bus2.disp_bcd !== 16'h00F0) begin n_err++; $display("FAIL illegal_up: got %h expected 00f0", bus2.disp_bcd); end
    press2(KS);
    press2(KD);
    n_cmp++; if (bus2.disp_bcd !== 16'h0000 || bus2.cursor !== 3'd1) begin n_err++; $display("FAIL illegal_down: got %h cur=%0d expected 0000 1", bus2.disp_bcd, bus2.cursor); end
  endtask

  task automatic test_reset_mid_edit();
    press(KM);
    press(KS);
    press(KU);
    n_cmp++; if (bus.disp_bcd !== 16'h1011 || bus.edit_mode !== 1'b1) begin n_err++; $display("FAIL pre_reset_edit: got %h edit=%b expected 1011 1", bus.disp_bcd, bus.edit_mode); end
    @(negedge clk); rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.value_bcd !== 16'h1000 || bus.disp_bcd !== 16'h1000) begin n_err++; $display("FAIL mid_rst_value: got %h/%h expected 1000/1000", bus.value_bcd, bus.disp_bcd); end
    n_cmp++; if (bus.edit_mode !== 1'b0 || bus.cursor !== 3'd0 || bus.disp_blank !== 4'b0 || bus.value_upd !== 1'b0) begin n_err++; $display("FAIL mid_rst_flags: got edit=%b cur=%0d blank=%b upd=%b expected 0 0 0000 0", bus.edit_mode, bus.cursor, bus.disp_blank, bus.value_upd); end
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (bus.value_bcd !== 16'h1000) begin n_err++; $display("FAIL post_rst_value: got %h expected 1000", bus.value_bcd); end
  endtask

  initial begin
    bus.key_pos  = 4'b0000;
    bus2.key_pos = 4'b0000;
    test_reset();
    test_commit();
    test_shift_wrap();
    test_timeout();
    test_ignore();
    test_illegal_digit();
    test_reset_mid_edit();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_drain: got %0d pending commits expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
